// File: rtl/reg_seq_pkg.sv
// Shared definitions for the register-window writer and reader sequencers:
// state encoding, default window geometry and register-index width.
package reg_seq_pkg;

    localparam int REG_IDX_W     = 5;
    localparam int IDX_W         = 4;
    localparam int DEFAULT_BASE  = 8;
    localparam int DEFAULT_STEPS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_STEP  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef logic [REG_IDX_W-1:0] regnum_t;

endpackage

// File: rtl/reg_reader_if.sv
// Request/readback bundle between a requester + register file (master side)
// and the reg_reader window walker (slave side).
interface reg_reader_if
    import reg_seq_pkg::*;
#(
    parameter int WIDTH = 32
) ();

    logic             go;
    logic             direction;
    logic [WIDTH-1:0] rdata;
    regnum_t          regnum;
    logic             rd_en;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] csum;

    modport master (
        output go, direction, rdata,
        input  regnum, rd_en, done, sum, csum
    );

    modport slave (
        input  go, direction, rdata,
        output regnum, rd_en, done, sum, csum
    );

endinterface

// File: rtl/reg_window_addr.sv
// Decodes the sequencer state into a register-file address and enable.
// Pure combinational so writer and reader present addresses identically.
module reg_window_addr
    import reg_seq_pkg::*;
#(
    parameter int BASE = DEFAULT_BASE
) (
    input  state_e           state,
    input  logic [IDX_W-1:0] idx,
    input  logic             dir,
    output regnum_t          regnum,
    output logic             rd_en
);

    localparam regnum_t BASE_R = regnum_t'(BASE);

    // 5-bit arithmetic: stepping past 0 or 31 wraps around by design.
    always_comb begin
        regnum = '0;
        rd_en  = 1'b0;
        unique case (state)
            ST_ARMED: begin
                regnum = BASE_R;
                rd_en  = 1'b1;
            end
            ST_STEP: begin
                regnum = dir ? (BASE_R + regnum_t'(idx)) : (BASE_R - regnum_t'(idx));
                rd_en  = 1'b1;
            end
            default: begin
                regnum = '0;
                rd_en  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/reg_reader.sv
// Walks a window of BASE plus STEPS registers after a go handshake and
// accumulates the read data into a modular sum and an XOR checksum.
module reg_reader
    import reg_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BASE  = DEFAULT_BASE,
    parameter int STEPS = DEFAULT_STEPS
) (
    input logic          clock,
    input logic          reset,
    reg_reader_if.slave  bus
);

    if (STEPS < 1 || STEPS > 15) begin : g_steps_check
        $error("reg_reader: STEPS must lie in 1..15");
    end

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEPS);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] csum_q, csum_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        sum_d   = sum_q;
        csum_d  = csum_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.go) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                // Reload rather than accumulate: a long ARMED dwell is one read.
                sum_d  = bus.rdata;
                csum_d = bus.rdata;
                if (!bus.go) begin
                    state_d = ST_STEP;
                    idx_d   = IDX_W'(1);
                    dir_d   = bus.direction;
                end
            end
            ST_STEP: begin
                sum_d  = sum_q + bus.rdata;
                csum_d = csum_q ^ bus.rdata;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.go) state_d = ST_ARMED;
            end
            default: state_d = ST_IDLE;
        endcase
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            sum_q   <= '0;
            csum_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            sum_q   <= sum_d;
            csum_q  <= csum_d;
            done_q  <= done_d;
        end
    end

    regnum_t regnum_w;
    logic    rd_en_w;

    reg_window_addr #(
        .BASE (BASE)
    ) u_addr (
        .state  (state_q),
        .idx    (idx_q),
        .dir    (dir_q),
        .regnum (regnum_w),
        .rd_en  (rd_en_w)
    );

    assign bus.regnum = regnum_w;
    assign bus.rd_en  = rd_en_w;
    assign bus.done   = done_q;
    assign bus.sum    = sum_q;
    assign bus.csum   = csum_q;

endmodule

// File: tb/tb_reg_reader.sv
// Bench for reg_reader: two instances (BASE=8 and BASE=2) share go/direction
// and a behavioural register file; table vectors, corner sequences, random windows.
module tb_reg_reader;
    import reg_seq_pkg::*;

    typedef logic [4:0][4:0] seq_t;

    typedef struct {
        bit          dir;
        seq_t        seq_a;
        logic [31:0] sum_a;
        logic [31:0] csum_a;
        seq_t        seq_b;
        logic [31:0] sum_b;
        logic [31:0] csum_b;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic        direction = 1'b0;
    logic [31:0] rf [32];

    int n_checks = 0;
    int n_fail   = 0;

    reg_reader_if #(.WIDTH(32)) ifa ();
    reg_reader_if #(.WIDTH(32)) ifb ();

    assign ifa.go        = go;
    assign ifa.direction = direction;
    assign ifa.rdata     = rf[ifa.regnum];
    assign ifb.go        = go;
    assign ifb.direction = direction;
    assign ifb.rdata     = rf[ifb.regnum];

    reg_reader #(.WIDTH(32), .BASE(8), .STEPS(4)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (ifa)
    );

    reg_reader #(.WIDTH(32), .BASE(2), .STEPS(4)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (ifb)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic identity_rf();
        for (int i = 0; i < 32; i++) rf[i] = i;
    endtask

    // Reference: the window is BASE then BASE+-1..BASE+-4, modulo 32.
    task automatic model(input int base, input bit dir, output seq_t seq,
                         output logic [31:0] s, output logic [31:0] c);
        s = '0;
        c = '0;
        for (int k = 0; k <= 4; k++) begin
            int r;
            r = (base + (dir ? k : 32 - k)) % 32;
            seq[k] = 5'(r);
            s = s + rf[r];
            c = c ^ rf[r];
        end
    endtask

    task automatic check_window(input bit dir, input int arm, input bit toggle,
                                input seq_t ea, input seq_t eb,
                                input logic [31:0] sa, input logic [31:0] ca,
                                input logic [31:0] sb, input logic [31:0] cb,
                                input string tag);
        go = 1'b1;
        direction = dir;
        repeat (arm) tick();
        chk({tag, " armed regnum_a"}, 32'(ifa.regnum), 32'(ea[0]));
        chk({tag, " armed regnum_b"}, 32'(ifb.regnum), 32'(eb[0]));
        chk({tag, " armed rd_en_a"}, 32'(ifa.rd_en), 32'd1);
        chk({tag, " armed done_a"}, 32'(ifa.done), 32'd0);
        if (arm >= 2) chk({tag, " armed sum_a"}, ifa.sum, rf[ea[0]]);
        go = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (toggle) direction = ~direction;
            $display("%s step %0d regnum_a=%0d regnum_b=%0d", tag, k, ifa.regnum, ifb.regnum);
            chk({tag, " step regnum_a"}, 32'(ifa.regnum), 32'(ea[k]));
            chk({tag, " step regnum_b"}, 32'(ifb.regnum), 32'(eb[k]));
            chk({tag, " step done_a"}, 32'(ifa.done), 32'd0);
        end
        tick();
        chk({tag, " done_a"}, 32'(ifa.done), 32'd1);
        chk({tag, " done_b"}, 32'(ifb.done), 32'd1);
        chk({tag, " sum_a"}, ifa.sum, sa);
        chk({tag, " csum_a"}, ifa.csum, ca);
        chk({tag, " sum_b"}, ifb.sum, sb);
        chk({tag, " csum_b"}, ifb.csum, cb);
        chk({tag, " done regnum_a"}, 32'(ifa.regnum), 32'd0);
        chk({tag, " done rd_en_a"}, 32'(ifa.rd_en), 32'd0);
        $display("%s window sum_a=%0d csum_a=%0d sum_b=%0d csum_b=%0d",
                 tag, ifa.sum, ifa.csum, ifb.sum, ifb.csum);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " regnum_a"}, 32'(ifa.regnum), 32'd0);
        chk({tag, " rd_en_a"}, 32'(ifa.rd_en), 32'd0);
        chk({tag, " done_a"}, 32'(ifa.done), 32'd0);
        chk({tag, " sum_a"}, ifa.sum, 32'd0);
        chk({tag, " csum_a"}, ifa.csum, 32'd0);
        chk({tag, " sum_b"}, ifb.sum, 32'd0);
        chk({tag, " done_b"}, 32'(ifb.done), 32'd0);
    endtask

    vec_t vecs [2];

    initial begin
        seq_t        ea, eb;
        logic [31:0] sa, ca, sb, cb;

        vecs[0].dir = 1'b1;
        vecs[0].seq_a = {5'd12, 5'd11, 5'd10, 5'd9, 5'd8};
        vecs[0].sum_a = 32'd50;  vecs[0].csum_a = 32'd12;
        vecs[0].seq_b = {5'd6, 5'd5, 5'd4, 5'd3, 5'd2};
        vecs[0].sum_b = 32'd20;  vecs[0].csum_b = 32'd6;
        vecs[1].dir = 1'b0;
        vecs[1].seq_a = {5'd4, 5'd5, 5'd6, 5'd7, 5'd8};
        vecs[1].sum_a = 32'd30;  vecs[1].csum_a = 32'd8;
        vecs[1].seq_b = {5'd30, 5'd31, 5'd0, 5'd1, 5'd2};
        vecs[1].sum_b = 32'd64;  vecs[1].csum_b = 32'd2;

        identity_rf();

        // Asynchronous reset before any clock edge.
        #2 reset = 1'b0;
        #1 check_zero("reset");
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        tick();
        check_zero("idle");

        for (int v = 0; v < 2; v++)
            check_window(vecs[v].dir, 3, 1'b0, vecs[v].seq_a, vecs[v].seq_b,
                         vecs[v].sum_a, vecs[v].csum_a, vecs[v].sum_b, vecs[v].csum_b,
                         vecs[v].dir ? "vec_up" : "vec_down");

        // Hold in DONE, then re-arm.
        check_window(1'b1, 3, 1'b0, vecs[0].seq_a, vecs[0].seq_b,
                     32'd50, 32'd12, 32'd20, 32'd6, "pre_hold");
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold done", 32'(ifa.done), 32'd1);
            chk("hold sum", ifa.sum, 32'd50);
            chk("hold regnum", 32'(ifa.regnum), 32'd0);
            chk("hold rd_en", 32'(ifa.rd_en), 32'd0);
        end
        go = 1'b1;
        tick();
        chk("rearm done", 32'(ifa.done), 32'd0);
        chk("rearm regnum", 32'(ifa.regnum), 32'd8);
        chk("rearm rd_en", 32'(ifa.rd_en), 32'd1);
        tick();
        chk("rearm sum", ifa.sum, 32'd8);
        rf[8] = 32'd77;
        tick();
        chk("armed tracks", ifa.sum, 32'd77);
        rf[8] = 32'd8;
        $display("hold/rearm sum_a=%0d", ifa.sum);

        // go raised during the last STEP: DONE first, then ARMED.
        go = 1'b0;
        repeat (4) tick();
        chk("late idx4 regnum", 32'(ifa.regnum), 32'd12);
        go = 1'b1;
        tick();
        chk("late done", 32'(ifa.done), 32'd1);
        chk("late sum", ifa.sum, 32'd50);
        tick();
        chk("late armed done", 32'(ifa.done), 32'd0);
        chk("late armed regnum", 32'(ifa.regnum), 32'd8);
        go = 1'b0;
        repeat (5) tick();
        chk("late rewindow done", 32'(ifa.done), 32'd1);
        chk("late rewindow sum", ifa.sum, 32'd50);
        $display("late go sum_a=%0d", ifa.sum);

        // Reset mid-STEP at idx=2.
        go = 1'b1;
        direction = 1'b1;
        repeat (2) tick();
        go = 1'b0;
        repeat (2) tick();
        chk("mid regnum idx2", 32'(ifa.regnum), 32'd10);
        #3 reset = 1'b0;
        #1 check_zero("mid_reset");
        @(negedge clock) reset = 1'b1;
        repeat (3) tick();
        check_zero("post_reset idle");
        check_window(1'b1, 3, 1'b0, vecs[0].seq_a, vecs[0].seq_b,
                     32'd50, 32'd12, 32'd20, 32'd6, "after_reset");

        // Direction toggling during STEP.
        check_window(1'b1, 2, 1'b1, vecs[0].seq_a, vecs[0].seq_b,
                     32'd50, 32'd12, 32'd20, 32'd6, "toggle");

        // Random register contents, direction, ARMED dwell and toggling.
        for (int t = 0; t < 25; t++) begin
            bit d, tg;
            int arm;
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            d   = 1'($urandom_range(0, 1));
            tg  = 1'($urandom_range(0, 1));
            arm = $urandom_range(1, 4);
            model(8, d, ea, sa, ca);
            model(2, d, eb, sb, cb);
            check_window(d, arm, tg, ea, eb, sa, ca, sb, cb, $sformatf("rand%0d", t));
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_reader.md
# reg_reader

Read-side counterpart of the lab's register-write sequencer. On a `go` handshake it walks a five-register window of the register file, starting at a base register and stepping up or down. It drives the register-file read port (`regnum`, `rd_en`) and accumulates the returned data into a running sum and an XOR checksum. It holds `done` until the next request.

## Interface
Parameters:
- `WIDTH`, default 32: register data width.
- `BASE`, default 8: first register read.
- `STEPS`, default 4: registers read after `BASE`. Legal range 1..15.

Ports:
- `clock`, input, 1: sole clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low; 0 forces reset state immediately.
- `go`, input, 1: request; level-sensitive handshake.
- `direction`, input, 1: 1 = step up (BASE+1…), 0 = step down (BASE−1…).
- `rdata`, input, WIDTH: combinational read data for `regnum`.
- `regnum`, output, 5: register-file read address.
- `rd_en`, output, 1: read-port enable.
- `done`, output, 1: window complete; results valid.
- `sum`, output, WIDTH: modular sum of all reads in the window.
- `csum`, output, WIDTH: XOR of all reads in the window.

## Operation
States:
- IDLE: power-up and reset state.
- ARMED
- STEP: with a 4-bit index `idx`, 1..STEPS.
- DONE

Transitions, evaluated at each rising edge:
- IDLE: `go`=1 → ARMED; otherwise stay in IDLE.
- ARMED: `go`=1 → stay in ARMED. `go`=0 → STEP with `idx`=1, `direction` latched into `dir_q`.
- STEP: `idx`<STEPS → STEP with `idx`+1. `idx`=STEPS → DONE. `go` and `direction` are ignored.
- DONE: `go`=1 → ARMED; otherwise stay in DONE.

Outputs per state:
- IDLE and DONE: `regnum`=0, `rd_en`=0.
- ARMED: `regnum`=BASE, `rd_en`=1. Each edge loads `sum`←`rdata` and `csum`←`rdata`; a repeated read does not accumulate.
- STEP: `regnum`=BASE+`idx` if `dir_q`=1, else BASE−`idx`. Computed modulo 32, so 5-bit wrap-around is legal and is not flagged. `rd_en`=1. Each edge applies `sum`←`sum`+`rdata` (carry discarded, WIDTH bits) and `csum`←`csum`^`rdata`.
- DONE: `done`=1; `sum` and `csum` held stable.
- `done`=0 in every other state.

Register updates:
- `sum` and `csum` change only in ARMED and STEP; they are held in IDLE and DONE.
- Reset (`reset`=0), at any time including mid-STEP: state→IDLE, `idx`=0, `dir_q`=0, `sum`=0, `csum`=0.
- Reset values of outputs: `regnum`=0, `rd_en`=0, `done`=0.
- No partial result survives reset.

## Timing
- All outputs are Moore, decoded from registered state only.
- `rdata` is sampled at the same edge that ends the cycle in which `regnum` was presented. The register file must return data combinationally within that cycle.
- Latency: with `go` sampled 0 in ARMED at edge k:
  - STEP `idx`=1 is visible from k; `idx`=STEPS from k+STEPS−1.
  - `done`=1 from edge k+STEPS; for STEPS=4, that is 4 cycles after the exit edge.
- Total reads per window: 1 + STEPS distinct registers. The ARMED dwell counts as one read regardless of length.
- `go` asserted on the same edge STEP would reach DONE: the transition to DONE still occurs, and `go` is honoured from DONE on the following edge.
- `go` held high continuously from DONE: the block stays in ARMED, and `sum` tracks r[BASE] each cycle.
- `direction` toggling during STEP has no effect; it is sampled only on the ARMED→STEP edge.

## Structure
Shared package `reg_seq_pkg`, common to writer and reader:
- state encoding constants: IDLE, ARMED, STEP, DONE;
- default `BASE`=8 and `STEPS`=4;
- the 5-bit register-index width.

Module layout:
- FSM, `idx` counter, and accumulators in `reg_reader` itself.
- One natural sub-module: `reg_window_addr`, combinational. It maps (state, `idx`, `dir_q`, BASE) to `regnum`/`rd_en`, and is reused by the writer.
- Parameter check on STEPS range at elaboration.

## Test plan
The register-file model returns r[i]=i.
- Up window: `reset` released, `go`=1 for 3 cycles, `direction`=1, then `go`=0. Required: `regnum` sequence 8,9,10,11,12; `done`=1 four cycles after the exit edge; `sum`=50; `csum`=12.
- Down window: same stimulus with `direction`=0. Required: `regnum` sequence 8,7,6,5,4; `sum`=30; `csum`=8.
- Hold in DONE: after the up window, keep `go`=0 for 10 cycles. Required: `done`=1 throughout, `sum`=50, `regnum`=0, `rd_en`=0. Then `go`=1. Required: ARMED next edge, `done`=0, `sum`=8.
- Reset mid-STEP: assert `reset`=0 asynchronously at STEP `idx`=2. Required: immediately `regnum`=0, `rd_en`=0, `done`=0, `sum`=0, `csum`=0, state IDLE. A following up window still yields 50.
- Direction toggle: toggle `direction` every cycle during STEP after latching 1. Required: `regnum` sequence 9,10,11,12 unchanged; `sum`=50.
- Wrap-around (BASE=2, STEPS=4, down): required `regnum` sequence 2,1,0,31,30; `sum`=64; `csum`=3^31^30=2.
